chan_mux_rr: RTL and testbench

- Parametrised, registered N-channel stream multiplexer with a valid/ready handshake on every input and on the output.
- Two modes:
  - Fixed mode: an explicit select input picks the channel.
  - Round-robin mode: the block arbitrates fairly among requesting channels.
- Sits between several producer blocks and one shared consumer.
- Supersedes the single-bit, two-input clocked mux for multi-bit, multi-source datapaths.

---
 rtl/chan_mux_rr.sv | 96 +++++++++
 tb/tb_chan_mux_rr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/chan_mux_rr.sv
// Registered N-channel valid/ready stream mux with fixed-select and round-robin modes.
// Optional output-transfer counter (xfer_count) is built when CHMUX_COUNT_EN is defined.
module chan_mux_rr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef CHMUX_COUNT_EN
  ,
  output logic [15:0]          xfer_count
`endif
);

  logic             load_en_c;
  logic             grant_vld_c;
  logic [SELW-1:0]  grant_c;
  logic [SELW-1:0]  idx_c;
  logic [WIDTH-1:0] grant_data_c;
  logic             in_xfer_c;
  logic             out_xfer_c;
  logic [SELW-1:0]  last;

  assign load_en_c  = !out_valid || out_ready;
  assign out_xfer_c = out_valid && out_ready;
  assign in_xfer_c  = rst_n && grant_vld_c && load_en_c;

  // Grant: explicit select, or first valid channel after the last one served
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    idx_c       = '0;
    if (mode) begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx_c = SELW'((32'(last) + k) % NCH);
        if (!grant_vld_c && in_valid[idx_c]) begin
          grant_vld_c = 1'b1;
          grant_c     = idx_c;
        end
      end
    end else if ((32'(sel) < NCH) && in_valid[sel]) begin
      grant_vld_c = 1'b1;
      grant_c     = sel;
    end
  end

  always_comb begin
    grant_data_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_c == SELW'(i)) grant_data_c = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready is held low in reset so nothing is accepted before the register is live
  always_comb begin
    in_ready = '0;
    if (in_xfer_c) in_ready[grant_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SELW'(NCH - 1);
    end else if (in_xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_c;
      out_chan  <= grant_c;
      if (mode) last <= grant_c;
    end else if (out_xfer_c) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CHMUX_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (out_xfer_c) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed self-checking bench for chan_mux_rr (NCH=4, WIDTH=8).
// Counter checks are compiled in only when CHMUX_COUNT_EN is defined.
module tb_chan_mux_rr;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;
`ifdef CHMUX_COUNT_EN
  logic [15:0]          xfer_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  chan_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CHMUX_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sparse round-robin vectors: in_valid per cycle and the channel that must win
  logic [3:0] sp_iv [9];
  int         sp_g  [9];

  initial begin
    sp_iv = '{4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1001, 4'b1001};
    sp_g  = '{3, 0, 3, 0, 3, 0, 1, 3, 0};

    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;

    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_out_chan",  32'(out_chan),  32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd0);
    tick();
    tick();
    check_eq("rst_in_ready_hold", 32'(in_ready), 32'd0);

    rst_n    = 1'b1;
    in_valid = 4'b0000;
    #1;
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("idle_out_valid", 32'(out_valid), 32'd0);

    // Fixed mode, sel=2
    sel       = 2'd2;
    in_valid  = 4'b0101;
    in_data   = {8'h33, 8'hA5, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    check_eq("fix_in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_eq("fix_out_valid", 32'(out_valid), 32'd1);
    check_eq("fix_out_data",  32'(out_data),  32'hA5);
    check_eq("fix_out_chan",  32'(out_chan),  32'd2);
    sel = 2'd1;
    #1;
    check_eq("fix_sel_invalid_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("fix_drain_valid", 32'(out_valid), 32'd0);
    check_eq("fix_drain_hold_data", 32'(out_data), 32'hA5);

    // Round-robin, all channels valid; fixed grant above must not have moved the pointer
    mode     = 1'b1;
    in_valid = 4'hF;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 9; k++) begin
      #1;
      check_eq($sformatf("rr_in_ready_%0d", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check_eq($sformatf("rr_out_valid_%0d", k), 32'(out_valid), 32'd1);
      check_eq($sformatf("rr_out_chan_%0d", k),  32'(out_chan),  32'(k % 4));
      check_eq($sformatf("rr_out_data_%0d", k),  32'(out_data),  32'(8'h10 + k % 4));
    end

    // Backpressure with channel 0 held
    out_ready = 1'b0;
    #1;
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp_data_%0d", c),  32'(out_data),  32'h10);
      check_eq($sformatf("bp_chan_%0d", c),  32'(out_chan),  32'd0);
      check_eq($sformatf("bp_ready_%0d", c), 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    check_eq("bp_release_chan", 32'(out_chan), 32'd1);
    check_eq("bp_release_data", 32'(out_data), 32'h11);

    // Sparse round-robin
    for (int s = 0; s < 9; s++) begin
      in_valid = sp_iv[s];
      #1;
      check_eq($sformatf("sp_in_ready_%0d", s), 32'(in_ready), 32'(4'b0001 << sp_g[s]));
      tick();
      check_eq($sformatf("sp_out_chan_%0d", s), 32'(out_chan), 32'(sp_g[s]));
      check_eq($sformatf("sp_out_data_%0d", s), 32'(out_data), 32'(8'h10 + sp_g[s]));
    end

    // Mid-stream reset: word discarded, pointer back to NCH-1
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_out_data",  32'(out_data),  32'd0);
    check_eq("mrst_in_ready",  32'(in_ready),  32'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'hF;
    #1;
    check_eq("mrst_first_grant", 32'(in_ready), 32'b0001);

`ifdef CHMUX_COUNT_EN
    check_eq("cnt_reset", 32'(xfer_count), 32'd0);
    tick();
    check_eq("cnt_first_load", 32'(xfer_count), 32'd0);
    repeat (65537) tick();
    check_eq("cnt_wrap", 32'(xfer_count), 32'd1);
    check_eq("cnt_wrap_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("cnt_mrst", 32'(xfer_count), 32'd0);
    check_eq("cnt_mrst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("cnt_mrst_grant", 32'(in_ready), 32'b0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
